// File: rtl/ready_sync_if.sv
// rtl/ready_sync_if.sv - ready gate / draw bundle between the control unit and ready_sync
interface ready_sync_if #(
    parameter int PLAYERS = 2,
    parameter int NUM_W   = 4
);
    logic [PLAYERS-1:0] READY;
    logic [3:0]         STATE;
    logic [NUM_W-1:0]   NUM;
    logic               OK;
    logic [PLAYERS-1:0] ARMED;
    logic               TO;

    modport master (
        output READY,
        output STATE,
        input  NUM,
        input  OK,
        input  ARMED,
        input  TO
    );

    modport slave (
        input  READY,
        input  STATE,
        output NUM,
        output OK,
        output ARMED,
        output TO
    );
endinterface

// File: rtl/ready_sync.sv
// rtl/ready_sync.sv - player ready gate and free-running number draw; READY_TIMEOUT_EN builds the partial-round timeout
module ready_sync #(
    parameter int          PLAYERS       = 2,
    parameter int          TICK_DIV      = 5_000_000,
    parameter int          NUM_MAX       = 9,
    parameter int          NUM_W         = 4,
    parameter logic [15:0] CLR_MASK      = 16'h0F40,
    parameter int          TIMEOUT_TICKS = 10
) (
    input  logic         CLK,
    input  logic         RST,
    ready_sync_if.slave  bus
);
    localparam int                 DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [NUM_W-1:0]   SEC_LAST = NUM_W'(NUM_MAX);
    localparam logic [PLAYERS-1:0] ALL_ON   = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PARTIAL = 2'd1,
        S_FIRE    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PLAYERS-1:0] armed_q, armed_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic               ok_q, ok_d;
    logic               to_q, to_d;

    logic [DIV_W-1:0]   div_q;
    logic [NUM_W-1:0]   sec_q;
    logic               tick;
    logic               clr;
    logic               timeout;

    assign tick = (div_q == DIV_LAST);
    assign clr  = CLR_MASK[bus.STATE];

    // The draw counter never pauses, so the drawn value depends on when the last player arms.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q <= '0;
            sec_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                sec_q <= (sec_q == SEC_LAST) ? '0 : sec_q + 1'b1;
            end
        end
    end

`ifdef READY_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    logic [TO_W-1:0] to_cnt_q;

    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_TICKS));

    // Held at zero outside PARTIAL so every entry starts a fresh count; saturates at the limit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            to_cnt_q <= '0;
        end else if (state_q != S_PARTIAL) begin
            to_cnt_q <= '0;
        end else if (tick && !timeout) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    // TIMEOUT_TICKS is only meaningful with the timeout built; this is constant false.
    assign timeout = (TIMEOUT_TICKS < 0);
`endif

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        num_d   = num_q;
        ok_d    = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!clr) begin
                    armed_d = armed_q | bus.READY;
                    if (armed_d == ALL_ON) begin
                        state_d = S_FIRE;
                    end else if (armed_d != '0) begin
                        state_d = S_PARTIAL;
                    end
                end
            end
            S_PARTIAL: begin
                if (clr) begin
                    state_d = S_IDLE;
                    armed_d = '0;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    armed_d = '0;
                    to_d    = 1'b1;
                end else begin
                    armed_d = armed_q | bus.READY;
                    if (armed_d == ALL_ON) begin
                        state_d = S_FIRE;
                    end
                end
            end
            S_FIRE: begin
                state_d = S_DONE;
                num_d   = sec_q;
                ok_d    = 1'b1;
            end
            S_DONE: begin
                if (clr) begin
                    state_d = S_IDLE;
                    armed_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                armed_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            armed_q <= '0;
            num_q   <= '0;
            ok_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            num_q   <= num_d;
            ok_q    <= ok_d;
            to_q    <= to_d;
        end
    end

    assign bus.NUM   = num_q;
    assign bus.OK    = ok_q;
    assign bus.ARMED = armed_q;
    assign bus.TO    = to_q;
endmodule

// File: tb/tb_ready_sync.sv
// tb/tb_ready_sync.sv - directed bench for ready_sync (PLAYERS=2, TICK_DIV=4, NUM_MAX=9, TIMEOUT_TICKS=3)
module tb_ready_sync;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    ready_sync_if #(.PLAYERS(2), .NUM_W(4)) bus ();

    ready_sync #(
        .PLAYERS      (2),
        .TICK_DIV     (4),
        .NUM_MAX      (9),
        .NUM_W        (4),
        .CLR_MASK     (16'h0F40),
        .TIMEOUT_TICKS(3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int total  = 0;
    int bad    = 0;
    int edges  = 0;
    int ok_cnt = 0;
    int to_cnt = 0;

    // Rising edges since reset release: div = edges%4, sec = (edges/4)%10.
    always @(posedge CLK or negedge RST) begin
        if (!RST) edges <= 0;
        else      edges <= edges + 1;
    end

    task automatic step();
        @(posedge CLK);
        #1;
        if (bus.OK === 1'b1) ok_cnt++;
        if (bus.TO === 1'b1) to_cnt++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clear_round();
        bus.READY = 2'b00;
        bus.STATE = 4'd8;
        step();
        bus.STATE = 4'd0;
        step();
    endtask

    task automatic wait_pos(input int p);
        int guard = 0;
        while ((edges % 40) != p && guard < 60) begin
            step();
            guard++;
        end
        total++;
        if ((edges % 40) != p) begin
            bad++;
            $display("FAIL wait_pos: edge phase %0d want %0d", edges % 40, p);
        end
    endtask

    task automatic test_reset();
        bus.READY = 2'b00;
        bus.STATE = 4'd0;
        RST = 1'b0;
        #12;
        total++;
        if ({bus.NUM, bus.OK, bus.ARMED, bus.TO} !== 8'h00) begin
            bad++;
            $display("FAIL reset_vals: got num=%0h ok=%0b armed=%0b to=%0b want all 0", bus.NUM, bus.OK, bus.ARMED, bus.TO);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        steps(3);
        total++;
        if ({bus.NUM, bus.OK, bus.ARMED, bus.TO} !== 8'h00) begin
            bad++;
            $display("FAIL reset_idle: got num=%0h ok=%0b armed=%0b to=%0b want all 0", bus.NUM, bus.OK, bus.ARMED, bus.TO);
        end
    endtask

    task automatic test_simultaneous();
        wait_pos(20);
        bus.READY = 2'b11;
        step();
        bus.READY = 2'b00;
        total++;
        if (bus.ARMED !== 2'b11 || bus.OK !== 1'b0) begin
            bad++;
            $display("FAIL sim_e0: got armed=%0b ok=%0b want armed=11 ok=0", bus.ARMED, bus.OK);
        end
        step();
        total++;
        if (bus.OK !== 1'b1 || bus.NUM !== 4'd5) begin
            bad++;
            $display("FAIL sim_e1: got ok=%0b num=%0d want ok=1 num=5", bus.OK, bus.NUM);
        end
        step();
        total++;
        if (bus.OK !== 1'b0 || bus.NUM !== 4'd5 || bus.ARMED !== 2'b11) begin
            bad++;
            $display("FAIL sim_e2: got ok=%0b num=%0d armed=%0b want ok=0 num=5 armed=11", bus.OK, bus.NUM, bus.ARMED);
        end
    endtask

    task automatic test_staggered();
        clear_round();
        total++;
        if (bus.ARMED !== 2'b00) begin
            bad++;
            $display("FAIL stag_clear: got armed=%0b want 00", bus.ARMED);
        end
        ok_cnt = 0;
        bus.READY = 2'b01;
        step();
        bus.READY = 2'b00;
        total++;
        if (bus.ARMED !== 2'b01) begin
            bad++;
            $display("FAIL stag_first: got armed=%0b want 01", bus.ARMED);
        end
        steps(2);
        bus.READY = 2'b10;
        step();
        bus.READY = 2'b00;
        total++;
        if (bus.ARMED !== 2'b11) begin
            bad++;
            $display("FAIL stag_second: got armed=%0b want 11", bus.ARMED);
        end
        repeat (6) begin
            bus.READY = 2'b11;
            step();
            bus.READY = 2'b00;
            step();
        end
        total++;
        if (ok_cnt != 1 || bus.ARMED !== 2'b11) begin
            bad++;
            $display("FAIL stag_repeat: got ok_count=%0d armed=%0b want ok_count=1 armed=11", ok_cnt, bus.ARMED);
        end
    endtask

    task automatic test_clear_decode();
        bus.STATE = 4'd7;
        step();
        bus.STATE = 4'd0;
        total++;
        if (bus.ARMED !== 2'b11) begin
            bad++;
            $display("FAIL clr_state7: got armed=%0b want 11", bus.ARMED);
        end
        bus.STATE = 4'd8;
        bus.READY = 2'b01;
        step();
        bus.STATE = 4'd0;
        bus.READY = 2'b00;
        total++;
        if (bus.ARMED !== 2'b00) begin
            bad++;
            $display("FAIL clr_state8: got armed=%0b want 00", bus.ARMED);
        end
        step();
        total++;
        if (bus.ARMED !== 2'b00) begin
            bad++;
            $display("FAIL clr_drop_ready: got armed=%0b want 00", bus.ARMED);
        end
        bus.READY = 2'b01;
        step();
        step();
        total++;
        if (bus.ARMED !== 2'b01) begin
            bad++;
            $display("FAIL clr_rearm_repeat: got armed=%0b want 01", bus.ARMED);
        end
        bus.READY = 2'b00;
        bus.STATE = 4'd6;
        step();
        bus.STATE = 4'd0;
        total++;
        if (bus.ARMED !== 2'b00) begin
            bad++;
            $display("FAIL clr_partial: got armed=%0b want 00", bus.ARMED);
        end
    endtask

    task automatic test_timeout();
        wait_pos(0);
        ok_cnt = 0;
        to_cnt = 0;
        bus.READY = 2'b01;
        step();
        bus.READY = 2'b00;
`ifdef READY_TIMEOUT_EN
        begin
            int n = 0;
            while (bus.TO !== 1'b1 && n < 30) begin
                step();
                n++;
            end
            total++;
            if (n != 12 || bus.ARMED !== 2'b00) begin
                bad++;
                $display("FAIL to_fire: got cycles=%0d armed=%0b want cycles=12 armed=00", n, bus.ARMED);
            end
            step();
            total++;
            if (bus.TO !== 1'b0 || to_cnt != 1 || ok_cnt != 0) begin
                bad++;
                $display("FAIL to_pulse: got to=%0b to_count=%0d ok_count=%0d want 0/1/0", bus.TO, to_cnt, ok_cnt);
            end
        end
`else
        steps(40);
        total++;
        if (bus.ARMED !== 2'b01 || to_cnt != 0 || ok_cnt != 0) begin
            bad++;
            $display("FAIL to_disabled: got armed=%0b to_count=%0d ok_count=%0d want 01/0/0", bus.ARMED, to_cnt, ok_cnt);
        end
        clear_round();
`endif
    endtask

    task automatic draw_at(input int p, input logic [3:0] expn);
        clear_round();
        wait_pos((p + 38) % 40);
        bus.READY = 2'b11;
        step();
        bus.READY = 2'b00;
        step();
        total++;
        if (bus.OK !== 1'b1 || bus.NUM !== expn) begin
            bad++;
            $display("FAIL draw_%0d: got ok=%0b num=%0d want ok=1 num=%0d", p, bus.OK, bus.NUM, expn);
        end
        step();
        total++;
        if (bus.OK !== 1'b0) begin
            bad++;
            $display("FAIL draw_%0d_okfall: got ok=%0b want 0", p, bus.OK);
        end
    endtask

    task automatic test_wrap_collision();
        draw_at(0, 4'd9);
        draw_at(1, 4'd0);
        draw_at(5, 4'd1);
        draw_at(20, 4'd4);
        draw_at(37, 4'd9);
        draw_at(22, 4'd5);
    endtask

    task automatic test_async_reset();
        clear_round();
        total++;
        if (bus.NUM !== 4'd5) begin
            bad++;
            $display("FAIL rst_pre_num: got num=%0d want 5", bus.NUM);
        end
        bus.READY = 2'b11;
        step();
        bus.READY = 2'b00;
        total++;
        if (bus.ARMED !== 2'b11) begin
            bad++;
            $display("FAIL rst_e0: got armed=%0b want 11", bus.ARMED);
        end
        #2;
        RST = 1'b0;
        #1;
        total++;
        if (bus.ARMED !== 2'b00 || bus.NUM !== 4'd0 || bus.OK !== 1'b0 || bus.TO !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: got armed=%0b num=%0d ok=%0b to=%0b want all 0", bus.ARMED, bus.NUM, bus.OK, bus.TO);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        ok_cnt = 0;
        steps(26);
        total++;
        if (ok_cnt != 0 || bus.ARMED !== 2'b00) begin
            bad++;
            $display("FAIL rst_no_ok: got ok_count=%0d armed=%0b want 0/00", ok_cnt, bus.ARMED);
        end
        bus.READY = 2'b01;
        step();
        bus.READY = 2'b10;
        step();
        bus.READY = 2'b00;
        step();
        total++;
        if (bus.OK !== 1'b1 || bus.NUM !== 4'd7 || ok_cnt != 1) begin
            bad++;
            $display("FAIL rst_rearm: got ok=%0b num=%0d ok_count=%0d want 1/7/1", bus.OK, bus.NUM, ok_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_staggered();
        test_clear_decode();
        test_timeout();
        test_wrap_collision();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
